// File: rtl/wr_arbiter_pkg.sv
// wr_arbiter_pkg: shared FSM encoding, sizing and round-robin pick for the write arbiter
package wr_arbiter_pkg;
    localparam int NREQ = 4;
    localparam int GIDW = 2;
    typedef enum logic {IDLE, GRANT} state_t;
    typedef logic [GIDW-1:0] gid_t;
    // Walk offsets high to low so the lowest offset from ptr wins
    function automatic gid_t rr_pick(input logic [NREQ-1:0] req, input gid_t ptr);
        gid_t pick = ptr;
        gid_t idx;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = ptr + gid_t'(i);
            if (req[idx]) pick = idx;
        end
        return pick;
    endfunction
endpackage

// File: rtl/wr_arbiter_if.sv
// wr_arbiter_if: requester-side request/data bus and arbiter status outputs
interface wr_arbiter_if #(parameter int WIDTH = 21);
    logic [3:0]       req;
    logic [WIDTH-1:0] data0;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic [WIDTH-1:0] data3;
    logic [3:0]       ack;
    logic [1:0]       grant_id;
    logic             busy;
    logic [WIDTH-1:0] reg_out;
    logic             out_valid;
    logic [15:0]      wr_count;
    modport master (output req, data0, data1, data2, data3,
                    input ack, grant_id, busy, reg_out, out_valid, wr_count);
    modport slave  (input req, data0, data1, data2, data3,
                    output ack, grant_id, busy, reg_out, out_valid, wr_count);
endinterface

// File: rtl/enable_reg.sv
// enable_reg: WIDTH-bit register loaded when enable is high, cleared by sync reset
module enable_reg #(parameter int WIDTH = 21) (
    input  logic             clk,
    input  logic             GlobalReset,
    input  logic             enable,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);
    always_ff @(posedge clk) begin
        if (GlobalReset) out <= '0;
        else if (enable) out <= in;
    end
endmodule

// File: rtl/wr_arbiter.sv
// wr_arbiter: round-robin arbiter committing one requester's data per two cycles into a shared register
module wr_arbiter
    import wr_arbiter_pkg::*;
#(
    parameter int WIDTH = 21,
    parameter int NREQ  = wr_arbiter_pkg::NREQ
) (
    input logic        clk,
    input logic        GlobalReset,
    wr_arbiter_if.slave bus
);
    state_t           state_q, state_d;
    gid_t             ptr_q, ptr_d;
    gid_t             gid_q, gid_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [15:0]      wr_count_q, wr_count_d;
    logic             out_valid_q;
    logic             busy;
    logic [WIDTH-1:0] data [NREQ];

    assign data = '{bus.data0, bus.data1, bus.data2, bus.data3};
    assign busy = state_q == GRANT;
    assign bus.busy = busy;
    assign bus.ack = busy ? 4'b0001 << gid_q : 4'b0000;
    assign bus.grant_id = gid_q;
    assign bus.wr_count = wr_count_q;
    assign bus.out_valid = out_valid_q;

    always_comb begin
        state_d = state_q;
        ptr_d = ptr_q;
        gid_d = gid_q;
        hold_d = hold_q;
        wr_count_d = wr_count_q;
        if (state_q == IDLE && |bus.req) begin
            state_d = GRANT;
            gid_d = rr_pick(bus.req, ptr_q);
            hold_d = data[gid_d];
        end else if (state_q == GRANT) begin
            state_d = IDLE;
            ptr_d = gid_q + gid_t'(1);
            wr_count_d = wr_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            state_q <= IDLE;
            ptr_q <= '0;
            gid_q <= '0;
            hold_q <= '0;
            wr_count_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            gid_q <= gid_d;
            hold_q <= hold_d;
            wr_count_q <= wr_count_d;
            out_valid_q <= busy;
        end
    end

    enable_reg #(.WIDTH(WIDTH)) u_reg (
        .clk(clk),
        .GlobalReset(GlobalReset),
        .enable(busy),
        .in(hold_q),
        .out(bus.reg_out)
    );
endmodule

// File: tb/tb_wr_arbiter.sv
// tb_wr_arbiter: directed vectors with hand-computed expectations for wr_arbiter
module tb_wr_arbiter;
    logic        clk = 1'b0;
    logic        GlobalReset;
    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] exp_wc = '0;

    wr_arbiter_if #(.WIDTH(21)) bus ();

    wr_arbiter #(.WIDTH(21), .NREQ(4)) dut (
        .clk(clk),
        .GlobalReset(GlobalReset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Request already set in an IDLE cycle: expect ack next cycle, commit the cycle after
    task automatic grant(input int id, input logic [20:0] d, input bit drop);
        logic [3:0] oh;
        oh = 4'b0001 << id;
        step();
        check("ack", 32'(bus.ack), 32'(oh));
        check("busy", 32'(bus.busy), 32'd1);
        check("grant_id", 32'(bus.grant_id), 32'(id));
        if (drop) bus.req[id] = 1'b0;
        step();
        exp_wc++;
        check("reg_out", 32'(bus.reg_out), 32'(d));
        check("out_valid", 32'(bus.out_valid), 32'd1);
        check("wr_count", 32'(bus.wr_count), 32'(exp_wc));
        check("ack_low", 32'(bus.ack), 32'd0);
    endtask

    initial begin
        GlobalReset = 1'b1;
        bus.req = '0;
        bus.data0 = '0;
        bus.data1 = '0;
        bus.data2 = '0;
        bus.data3 = '0;
        step();
        step();
        GlobalReset = 1'b0;
        check("rst_ack", 32'(bus.ack), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_reg_out", 32'(bus.reg_out), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_wr_count", 32'(bus.wr_count), 32'd0);
        check("rst_grant_id", 32'(bus.grant_id), 32'd0);
        step();
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_ack", 32'(bus.ack), 32'd0);

        bus.req = 4'b0100;
        bus.data2 = 21'h1ABCD;
        grant(2, 21'h1ABCD, 1'b1);
        step();
        check("valid_pulse", 32'(bus.out_valid), 32'd0);
        check("reg_hold", 32'(bus.reg_out), 32'h1ABCD);
        check("hold_grant_id", 32'(bus.grant_id), 32'd2);

        bus.req = 4'b1000;
        bus.data3 = 21'h00033;
        grant(3, 21'h00033, 1'b1);
        bus.req = 4'b1001;
        bus.data0 = 21'h00010;
        grant(0, 21'h00010, 1'b1);
        grant(3, 21'h00033, 1'b1);

        bus.req = 4'b1111;
        bus.data0 = 21'd1;
        bus.data1 = 21'd2;
        bus.data2 = 21'd3;
        bus.data3 = 21'd4;
        grant(0, 21'd1, 1'b0);
        grant(1, 21'd2, 1'b0);
        grant(2, 21'd3, 1'b0);
        grant(3, 21'd4, 1'b0);
        grant(0, 21'd1, 1'b0);
        bus.req = '0;

        bus.req = 4'b0001;
        bus.data0 = 21'h00011;
        step();
        check("late_ack", 32'(bus.ack), 32'h1);
        bus.data0 = 21'h00022;
        bus.req = '0;
        step();
        exp_wc++;
        check("late_reg_out", 32'(bus.reg_out), 32'h00011);
        check("late_wr_count", 32'(bus.wr_count), 32'(exp_wc));

        bus.req = 4'b0010;
        bus.data1 = 21'h00055;
        step();
        check("abort_ack", 32'(bus.ack), 32'h2);
        GlobalReset = 1'b1;
        bus.req = '0;
        step();
        GlobalReset = 1'b0;
        exp_wc = '0;
        check("abort_reg_out", 32'(bus.reg_out), 32'd0);
        check("abort_wr_count", 32'(bus.wr_count), 32'd0);
        check("abort_ack_low", 32'(bus.ack), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_grant_id", 32'(bus.grant_id), 32'd0);
        bus.req = 4'b1111;
        bus.data0 = 21'd1;
        grant(0, 21'd1, 1'b0);
        bus.req = '0;
        step();

        force dut.wr_count_q = 16'hFFFF;
        bus.req = 4'b0100;
        step();
        check("wrap_pre", 32'(bus.wr_count), 32'hFFFF);
        check("wrap_ack", 32'(bus.ack), 32'h4);
        release dut.wr_count_q;
        bus.req = '0;
        step();
        check("wrap_wr_count", 32'(bus.wr_count), 32'h0);
        check("wrap_reg_out", 32'(bus.reg_out), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/wr_arbiter.md
WR_ARBITER -- requirements
Module: wr_arbiter

Interface
REQ-001 Parameter WIDTH, default 21, data width of the shared register.
REQ-002 Parameter NREQ, default 4, number of requesters; only 4 is supported.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 GlobalReset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 req  input  4  per-requester write request; requester holds it high until its ack.
REQ-006 data0..data3  input  WIDTH each  per-requester write data, stable while its req is high.
REQ-007 ack  output  4  one-hot, one-cycle grant/acknowledge pulse.
REQ-008 grant_id  output  2  index of the requester currently or last granted.
REQ-009 busy  output  1  high while FSM is in GRANT.
REQ-010 reg_out  output  WIDTH  contents of the shared register.
REQ-011 out_valid  output  1  one-cycle pulse when reg_out holds newly written data.
REQ-012 wr_count  output  16  total committed writes since reset.

Function
REQ-013 FSM has two states, IDLE and GRANT; reset state is IDLE.
REQ-014 IDLE with req==0: stay in IDLE; ack, busy and the register enable stay low.
REQ-015 IDLE with req!=0: select a winner by round-robin from pointer ptr, register it into grant_id and its data into a WIDTH-bit holding register, then go to GRANT.
REQ-016 Round-robin: search order is ptr, ptr+1, ptr+2, ptr+3 (mod 4); first set req wins.
REQ-017 GRANT lasts exactly one cycle; busy=1, ack[grant_id]=1, register enable=1, register input = holding register; next state IDLE.
REQ-018 On leaving GRANT: ptr <= grant_id+1 mod 4 (3 wraps to 0); wr_count <= wr_count+1, wrapping at 16'hFFFF -> 0.
REQ-019 reg_out updates on the posedge ending the GRANT cycle; out_valid=1 in the following cycle only.
REQ-020 Latency: req rising in IDLE cycle t -> ack in cycle t+1 -> reg_out new value and out_valid in cycle t+2.
REQ-021 Throughput: at most one grant every 2 cycles. Requester drops req at the posedge after ack, so it is not re-granted in the IDLE cycle after GRANT.
REQ-022 Requests arriving during GRANT are not lost; they are evaluated in the next IDLE cycle.
REQ-023 All four req high continuously -> grants cycle 0,1,2,3,0,... with no requester skipped.
REQ-024 Data on data0..3 is sampled only in the IDLE arbitration cycle; later changes do not affect the committed value.
REQ-025 reg_out holds its value when no GRANT occurs.

Reset
REQ-026 GlobalReset high at a posedge: FSM->IDLE, ptr=0, grant_id=0, holding reg=0, reg_out=0, wr_count=0, ack=0, busy=0, out_valid=0.
REQ-027 Reset during GRANT aborts the write: reg_out becomes 0 and wr_count and ptr are not advanced.
REQ-028 Reset has priority over all other events in the same cycle.
REQ-029 First arbitration after reset uses ptr=0, so requester 0 has highest priority.

Structure
REQ-030 Shared package holds the FSM state encoding (IDLE, GRANT), NREQ, and the grant-index width of 2.
REQ-031 The shared register is one enable_reg instance (clk, GlobalReset, enable, in, out) driven by the FSM; arbitration, ptr, counter and out_valid are in wr_arbiter.

Verification
REQ-032 Reset, then req=4'b0100 with data2=21'h1ABCD held until ack -> ack=4'b0100 one cycle later, then reg_out=21'h1ABCD with out_valid=1 the next cycle, wr_count=1.
REQ-033 req=4'b1111 held (each requester re-asserts after ack), data_i=i+1 -> grant order 0,1,2,3,0; reg_out sequence 1,2,3,4,1; ack every 2nd cycle.
REQ-034 After a grant to 3, apply req=4'b1001 -> grant to 0 (pointer wrapped), then grant to 3.
REQ-035 GlobalReset asserted during GRANT with data1=21'h00055 -> reg_out=0, wr_count=0, ack=0 next cycle; first post-reset grant with req=4'b1111 goes to 0.
REQ-036 Preload wr_count to 16'hFFFF via 65535 writes (or force), then one write -> wr_count=16'h0000.
REQ-037 Change data0 from 21'h00011 to 21'h00022 during GRANT -> reg_out=21'h00011.
